// File: rtl/std_gray_count_receiver.sv
// std_gray_count_receiver
//
// Receive side of a gray-coded count link. The incoming gray value is passed
// through an optional synchronizer chain, captured in a sample register, and
// decoded to binary. The block also reports how far the count advanced since
// the previous sample and flags any transition that changed more than one bit.
//
// Parameters:
//   WIDTH         - count width in bits (count range 0 .. 2^WIDTH-1)
//   SYNC_STAGES   - synchronizer flops on i_gray (0..4); 0 means i_gray is
//                   already in the i_clk domain
//   INITIAL_COUNT - binary count presented after reset
//
// Ports:
//   i_clk        - clock
//   i_rst        - asynchronous active-high reset
//   i_clear      - for one cycle forces o_error, o_delta and o_update to 0
//   i_gray       - incoming gray-coded count
//   o_count      - decoded binary count
//   o_count_gray - synchronized gray value that o_count was decoded from
//   o_delta      - binary advance since the previous sample, modulo 2^WIDTH
//   o_update     - one-cycle pulse when o_count changed
//   o_error      - sticky flag for a multi-bit gray transition
//
// Configuration macro:
//   STD_GRAY_COUNT_RECEIVER_CHECK_EN - when defined, the multi-bit transition
//   checker and the sticky o_error flop are built; otherwise o_error is tied
//   low and i_clear only affects o_delta and o_update.

module std_gray_count_receiver #(
  parameter int               WIDTH         = 2,
  parameter int               SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] INITIAL_COUNT = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_gray,
  output logic [WIDTH-1:0] o_delta,
  output logic             o_update,
  output logic             o_error
);

  localparam logic [WIDTH-1:0] INIT_GRAY = INITIAL_COUNT ^ (INITIAL_COUNT >> 1);

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] g_new;
  logic [WIDTH-1:0] bin_new;
  logic             changed;
  logic             report;

  // Synchronizer chain. Flops reset to the gray code of INITIAL_COUNT so the
  // first sample after reset sees no transition when the input matches it.
  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign g_new = i_gray;
    end else begin : g_sync
      logic [WIDTH-1:0] stage [SYNC_STAGES];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            stage[s] <= INIT_GRAY;
          end
        end else begin
          stage[0] <= i_gray;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            stage[s] <= stage[s-1];
          end
        end
      end

      assign g_new = stage[SYNC_STAGES-1];
    end
  endgenerate

  assign bin_new = gray_to_bin(g_new);
  assign changed = (g_new != o_count_gray);
  // A clear suppresses the delta/update report but never the sample itself.
  assign report  = changed && !i_clear;

  // Sample register. o_count holds dec(o_count_gray), so the difference with
  // it gives the modulo-2^WIDTH advance, including the wrap from max to 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count_gray <= INIT_GRAY;
      o_count      <= INITIAL_COUNT;
      o_delta      <= '0;
      o_update     <= 1'b0;
    end else begin
      o_update <= report;
      o_delta  <= report ? (bin_new - o_count) : '0;
      if (changed) begin
        o_count_gray <= g_new;
        o_count      <= bin_new;
      end
    end
  end

`ifdef STD_GRAY_COUNT_RECEIVER_CHECK_EN
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  // More than one bit set in diff iff clearing its lowest set bit leaves
  // something behind.
  assign diff      = g_new ^ o_count_gray;
  assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;

  // Sticky error; clear has priority over a same-cycle illegal transition.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_error <= 1'b0;
    end else if (i_clear) begin
      o_error <= 1'b0;
    end else if (multi_bit) begin
      o_error <= 1'b1;
    end
  end
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_std_gray_count_receiver.sv
// tb_std_gray_count_receiver
//
// Bench for std_gray_count_receiver. Main instance: WIDTH=4, SYNC_STAGES=2,
// INITIAL_COUNT=5, compared every cycle against a behavioural model built on
// a delay queue and table-lookup gray decoding. Second instance: SYNC_STAGES=0,
// INITIAL_COUNT=0, driven with a continuous increment ramp.

module tb_std_gray_count_receiver;

  logic       clock;
  logic       reset;
  logic       clear;
  logic [3:0] grayIn;
  logic [3:0] count, countGray, delta;
  logic       update, error;

  logic [3:0] grayIn0;
  logic [3:0] count0, countGray0, delta0;
  logic       update0, error0;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [3:0] delayQ[$];
  logic [3:0] mGray, mCount, mDelta;
  logic       mUpdate, mError;

  std_gray_count_receiver #(.WIDTH(4), .SYNC_STAGES(2), .INITIAL_COUNT(4'd5)) dut (
    .i_clk(clock), .i_rst(reset), .i_clear(clear), .i_gray(grayIn),
    .o_count(count), .o_count_gray(countGray), .o_delta(delta),
    .o_update(update), .o_error(error)
  );

  std_gray_count_receiver #(.WIDTH(4), .SYNC_STAGES(0), .INITIAL_COUNT(4'd0)) dut0 (
    .i_clk(clock), .i_rst(reset), .i_clear(clear), .i_gray(grayIn0),
    .o_count(count0), .o_count_gray(countGray0), .o_delta(delta0),
    .o_update(update0), .o_error(error0)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [3:0] toGray(input int n);
    int m;
    m = n % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  // Decode by searching the code table for the matching count
  function automatic logic [3:0] fromGray(input logic [3:0] g);
    for (int n = 0; n < 16; n++) begin
      if (toGray(n) == g) return 4'(n);
    end
    return 4'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    delayQ  = {toGray(5), toGray(5)};
    mGray   = toGray(5);
    mCount  = 4'd5;
    mDelta  = 4'd0;
    mUpdate = 1'b0;
    mError  = 1'b0;
  endtask

  task automatic checkMain(input string tag);
    checkOutput({tag, ".count"},     32'(count),     32'(mCount));
    checkOutput({tag, ".countGray"}, 32'(countGray), 32'(mGray));
    checkOutput({tag, ".delta"},     32'(delta),     32'(mDelta));
    checkOutput({tag, ".update"},    32'(update),    32'(mUpdate));
    checkOutput({tag, ".error"},     32'(error),     32'(mError));
  endtask

  // Drive one cycle: inputs set while clock is low, model advanced on the
  // rising edge, outputs compared 1 unit later, return at the falling edge.
  task automatic applyStimulus(input logic [3:0] g, input logic clr);
    logic [3:0] gNew;
    logic       changed;
    int         bitsChanged;
    grayIn = g;
    clear  = clr;
    @(posedge clock);
    delayQ.push_back(g);
    gNew        = delayQ.pop_front();
    changed     = (gNew != mGray);
    bitsChanged = $countones(gNew ^ mGray);
    mUpdate     = changed && !clr;
    mDelta      = mUpdate ? 4'(fromGray(gNew) - mCount) : 4'd0;
`ifdef STD_GRAY_COUNT_RECEIVER_CHECK_EN
    mError = clr ? 1'b0 : (mError || bitsChanged > 1);
`else
    mError = 1'b0;
`endif
    if (changed) begin
      mGray  = gNew;
      mCount = fromGray(gNew);
    end
    #1;
    checkMain("main");
    @(negedge clock);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".count"},      32'(count),      32'd5);
    checkOutput({tag, ".countGray"},  32'(countGray),  32'b0111);
    checkOutput({tag, ".delta"},      32'(delta),      32'd0);
    checkOutput({tag, ".update"},     32'(update),     32'd0);
    checkOutput({tag, ".error"},      32'(error),      32'd0);
    checkOutput({tag, ".count0"},     32'(count0),     32'd0);
    checkOutput({tag, ".countGray0"}, 32'(countGray0), 32'd0);
    checkOutput({tag, ".update0"},    32'(update0),    32'd0);
    checkOutput({tag, ".delta0"},     32'(delta0),     32'd0);
  endtask

  initial begin
    int cur;
    int r;

    // Power-on reset
    reset   = 1'b1;
    clear   = 1'b0;
    grayIn  = toGray(5);
    grayIn0 = toGray(0);
    modelReset();
    repeat (2) @(negedge clock);
    checkResetValues("reset");
    reset = 1'b0;

    // Hold, then single step 5 -> 6
    repeat (3) applyStimulus(toGray(5), 1'b0);
    repeat (4) applyStimulus(toGray(6), 1'b0);
    checkOutput("step.count", 32'(count), 32'd6);

    // Back-to-back increments up to 15, then wrap to 0, then step down to 15
    for (int n = 7; n <= 15; n++) applyStimulus(toGray(n), 1'b0);
    repeat (3) applyStimulus(toGray(15), 1'b0);
    applyStimulus(toGray(0), 1'b0);
    applyStimulus(toGray(0), 1'b0);
    applyStimulus(toGray(0), 1'b0);
    checkOutput("wrap.delta", 32'(delta), 32'd1);
    repeat (2) applyStimulus(toGray(0), 1'b0);
    applyStimulus(toGray(15), 1'b0);
    applyStimulus(toGray(15), 1'b0);
    applyStimulus(toGray(15), 1'b0);
    checkOutput("down.delta", 32'(delta), 32'd15);
    repeat (2) applyStimulus(toGray(15), 1'b0);

    // Illegal two-bit jump 6 (0101) -> 8 (1100), error held, then cleared
    repeat (4) applyStimulus(toGray(6), 1'b0);
    repeat (5) applyStimulus(toGray(8), 1'b0);
    applyStimulus(toGray(8), 1'b1);
    repeat (2) applyStimulus(toGray(8), 1'b0);

    // Illegal jump 8 (1100) -> 6 (0101) with clear on the sampling edge
    applyStimulus(toGray(6), 1'b0);
    applyStimulus(toGray(6), 1'b0);
    applyStimulus(toGray(6), 1'b1);
    checkOutput("clearWins.error", 32'(error), 32'd0);
    checkOutput("clearWins.count", 32'(count), 32'd6);
    repeat (2) applyStimulus(toGray(6), 1'b0);

    // Continuous increment on the zero-stage instance, wrapping back to 0
    for (int k = 1; k <= 19; k++) begin
      grayIn0 = toGray(k);
      applyStimulus(toGray(6), 1'b0);
      checkOutput("ramp.update0", 32'(update0), 32'd1);
      checkOutput("ramp.delta0",  32'(delta0),  32'd1);
      checkOutput("ramp.count0",  32'(count0),  32'(k % 16));
      checkOutput("ramp.error0",  32'(error0),  32'd0);
    end

    // Asynchronous reset mid-run, checked before any clock edge
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("midReset");
    modelReset();
    grayIn0 = toGray(0);
    @(negedge clock);
    reset = 1'b0;

    // Randomized mix of steps, holds, jumps and clears
    cur = 5;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       cur = (cur + 1) % 16;
      else if (r < 7)  cur = (cur + 15) % 16;
      else if (r == 7) cur = $urandom_range(0, 15);
      applyStimulus(toGray(cur), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
